// File: rtl/ext_pipe_if.sv
// Valid/ready bus between decode and ext_pipe: immediate/mode in, operand/err out.
interface ext_pipe_if #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  in_imm;
  logic [2:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/ext_pipe.sv
// Pipelined immediate extender, one registered stage with valid/ready on both sides.
// Optional one-entry skid buffer (breaks out_ready->in_ready path) under `EXT_SKID_EN.
module ext_pipe #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    ext_pipe_if.slave  bus
);
    localparam int PAD = DATA_W - IMM_W;

    generate
        if (DATA_W < IMM_W + 2) begin : g_bad_width
            $error("ext_pipe: DATA_W must be >= IMM_W + 2");
        end
    endgenerate

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } res_t;

    function automatic res_t ext(input logic [IMM_W-1:0] imm, input logic [2:0] mode);
        res_t              r;
        logic [DATA_W-1:0] zx;
        logic [DATA_W-1:0] sx;
        zx     = {{PAD{1'b0}}, imm};
        sx     = {{PAD{imm[IMM_W-1]}}, imm};
        r.data = zx;
        r.err  = 1'b0;
        case (mode)
            3'b000:  r.data = zx;
            3'b001:  r.data = sx;
            3'b010:  r.data = {imm, {PAD{1'b0}}};
            3'b011:  r.data = sx << 2;
            3'b100:  r.data = zx << 2;
            default: r.err  = 1'b1;
        endcase
        return r;
    endfunction

    res_t out_q;
    logic out_vld;
    res_t new_res;
    logic in_xfer;
    logic out_xfer;

    assign new_res  = ext(bus.in_imm, bus.in_mode);
    assign out_xfer = out_vld & bus.out_ready;
    assign in_xfer  = bus.in_valid & bus.in_ready;

    assign bus.out_valid = out_vld;
    assign bus.out_data  = out_q.data;
    assign bus.out_err   = out_q.err;

`ifdef EXT_SKID_EN
    res_t skid_q;
    logic skid_vld;

    // Registered ready: a full skid is the only thing that can stall upstream.
    assign bus.in_ready = ~skid_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            out_vld  <= 1'b0;
            skid_q   <= '0;
            skid_vld <= 1'b0;
        end else if (flush) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
        end else if (skid_vld) begin
            if (out_xfer) begin
                out_q    <= skid_q;
                skid_vld <= 1'b0;
            end
        end else if (in_xfer) begin
            if (out_vld && !bus.out_ready) begin
                skid_q   <= new_res;
                skid_vld <= 1'b1;
            end else begin
                out_q   <= new_res;
                out_vld <= 1'b1;
            end
        end else if (out_xfer) begin
            out_vld <= 1'b0;
        end
    end
`else
    assign bus.in_ready = ~out_vld | bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            out_vld <= 1'b0;
        end else if (flush) begin
            out_vld <= 1'b0;
        end else if (in_xfer) begin
            out_q   <= new_res;
            out_vld <= 1'b1;
        end else if (out_xfer) begin
            out_vld <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: directed mode/backpressure/flush/reset cases plus a random stream.
module tb_ext_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n_pop = 0;
  logic [32:0] sb_q[$];

  ext_pipe_if #(.IMM_W(16), .DATA_W(32)) bus ();

  ext_pipe #(.IMM_W(16), .DATA_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

`ifdef EXT_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference extension for IMM_W=16, DATA_W=32; returns {err, data}.
  function automatic logic [32:0] ref_ext(input logic [15:0] imm, input logic [2:0] mode);
    logic [31:0] zx, sx;
    zx = {16'h0000, imm};
    sx = imm[15] ? (zx | 32'hFFFF_0000) : zx;
    case (mode)
      3'd0:    return {1'b0, zx};
      3'd1:    return {1'b0, sx};
      3'd2:    return {1'b0, zx * 32'd65536};
      3'd3:    return {1'b0, sx * 32'd4};
      3'd4:    return {1'b0, zx * 32'd4};
      default: return {1'b1, zx};
    endcase
  endfunction

  // Scoreboard monitor: the transfers that happen at the next rising edge.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst_n || flush) begin
      sb_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          n_pop++;
          chk("sb_data", {32'd0, bus.out_data}, {32'd0, e[31:0]});
          chk("sb_err", {63'd0, bus.out_err}, {63'd0, e[32]});
        end
      end
      if (bus.in_valid && bus.in_ready) sb_q.push_back(ref_ext(bus.in_imm, bus.in_mode));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one item and hold it until accepted (bounded).
  task automatic xfer(input logic [15:0] imm, input logic [2:0] mode);
    bit acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_imm   = imm;
    bus.in_mode  = mode;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
    end
    bus.in_valid = 1'b0;
    if (!acc) chk("xfer_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && bus.out_valid; i++) step();
    chk({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd0);
    chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    logic [15:0] mimm[5];
    logic [31:0] mexp[5];
    logic [15:0] cur;
    bit acc;
    int sent, cyc, pop0;

    bus.in_valid = 1'b0; bus.in_imm = '0; bus.in_mode = '0; bus.out_ready = 1'b1;
    mexp = '{32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000, 32'hFFFE_0004, 32'h0002_0004};

    // Reset state
    #2;
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_data", {32'd0, bus.out_data}, 64'd0);
    chk("rst_err", {63'd0, bus.out_err}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Mode sweep: each result visible right after its transfer edge
    for (int m = 0; m < 5; m++) begin
      xfer(16'h8001, 3'(m));
      chk($sformatf("mode%0d_valid", m), {63'd0, bus.out_valid}, 64'd1);
      chk($sformatf("mode%0d_data", m), {32'd0, bus.out_data}, {32'd0, mexp[m]});
      chk($sformatf("mode%0d_err", m), {63'd0, bus.out_err}, 64'd0);
    end
    xfer(16'h1234, 3'd6);
    chk("illegal_data", {32'd0, bus.out_data}, 64'h0000_1234);
    chk("illegal_err", {63'd0, bus.out_err}, 64'd1);
    drain("sweep");

    // Backpressure: A held at output, B (and C with skid) queued upstream
    bus.out_ready = 1'b0;
    xfer(16'h00AA, 3'd0);
    chk("bp_first", {32'd0, bus.out_data}, 64'h0000_00AA);
    cur = 16'h00BB;
    bus.in_valid = 1'b1; bus.in_imm = cur; bus.in_mode = 3'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_in_ready%0d", k), {63'd0, bus.in_ready}, {63'd0, SKID && (k == 0)});
      chk($sformatf("bp_hold_data%0d", k), {32'd0, bus.out_data}, 64'h0000_00AA);
      chk($sformatf("bp_hold_valid%0d", k), {63'd0, bus.out_valid}, 64'd1);
      acc = bus.in_ready;
      step();
      if (acc) begin
        cur = 16'h00CC;
        bus.in_imm = cur; bus.in_mode = 3'd4;
      end
    end
    bus.out_ready = 1'b1;
    xfer(cur, bus.in_mode);
    drain("bp");

    // Flush with output full (and skid full when built)
    bus.out_ready = 1'b0;
    xfer(16'h0111, 3'd0);
    bus.in_valid = 1'b1; bus.in_imm = 16'h0222; bus.in_mode = 3'd0;
    step();
    flush = 1'b1; bus.in_imm = 16'h0333;
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("flush_no_stale%0d", k), {63'd0, bus.out_valid}, 64'd0);
    end

    // Async reset during a stall
    bus.out_ready = 1'b0;
    xfer(16'h1234, 3'd7);
    chk("prerst_err", {63'd0, bus.out_err}, 64'd1);
    step();
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("async_rst_data", {32'd0, bus.out_data}, 64'd0);
    chk("async_rst_err", {63'd0, bus.out_err}, 64'd0);
    chk("async_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    step();
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Random stream with random backpressure
    pop0 = n_pop; sent = 0; cyc = 0;
    while (sent < 100 && cyc < 3000) begin
      if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
        bus.in_valid = 1'b1;
        bus.in_imm   = 16'($urandom);
        bus.in_mode  = 3'($urandom_range(0, 7));
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      step();
      cyc++;
      if (acc) begin
        sent++;
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    chk("stream_sent", 64'(sent), 64'd100);
    drain("stream");
    chk("stream_out_cnt", 64'(n_pop - pop0), 64'd100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
